// File: rtl/imm_encoder_pkg.sv
// Shared types and constants for the immediate encoder.
//   immsrc_e     : immediate format selector (I/S/B/J)
//   IMM_W_*      : signed range width of each format's immediate
//   req_t        : request captured by stage 1
//   fits_signed(): true when a 32-bit value is representable in w signed bits
package imm_encoder_pkg;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } immsrc_e;

  localparam int unsigned IMM_W_I = 12;
  localparam int unsigned IMM_W_S = 12;
  localparam int unsigned IMM_W_B = 13;
  localparam int unsigned IMM_W_J = 21;

  typedef struct packed {
    immsrc_e     src;
    logic [31:0] imm;
    logic [31:0] base;
  } req_t;

  // A value fits in w signed bits when bits [31:w-1] are all copies of the sign.
  function automatic logic fits_signed(logic [31:0] v, int unsigned w);
    logic [31:0] hi;
    hi = $unsigned($signed(v) >>> (w - 1));
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// Request/response bundle of the immediate encoder.
//   in_valid/in_ready   : request handshake
//   immsrc, imm, base   : format, signed immediate, instruction template
//   out_valid/out_ready : result handshake
//   instr, err          : encoded instruction, out-of-range flag
//   err_cnt             : saturating count of delivered results with err set
// master = producer/consumer side, slave = encoder side.
interface imm_encoder_if #(parameter int ERR_CNT_W = 8);
  logic                 in_valid;
  logic                 in_ready;
  logic [1:0]           immsrc;
  logic [31:0]          imm;
  logic [31:0]          base;
  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          instr;
  logic                 err;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    output in_valid, immsrc, imm, base, out_ready,
    input  in_ready, out_valid, instr, err, err_cnt
  );

  modport slave (
    input  in_valid, immsrc, imm, base, out_ready,
    output in_ready, out_valid, instr, err, err_cnt
  );
endinterface

// File: rtl/imm_range_check.sv
// Combinational range check: flags an immediate that the selected format
// cannot represent (sign range, plus even-alignment for B and J).
//   imm_i    : signed immediate
//   immsrc_i : format
//   err_o    : 1 when not representable
module imm_range_check
  import imm_encoder_pkg::*;
(
  input  logic [31:0] imm_i,
  input  immsrc_e     immsrc_i,
  output logic        err_o
);

  always_comb begin
    err_o = 1'b0;
    case (immsrc_i)
      IMM_I:   err_o = !fits_signed(imm_i, IMM_W_I);
      IMM_S:   err_o = !fits_signed(imm_i, IMM_W_S);
      IMM_B:   err_o = !fits_signed(imm_i, IMM_W_B) || imm_i[0];
      IMM_J:   err_o = !fits_signed(imm_i, IMM_W_J) || imm_i[0];
      default: err_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage immediate encoder: packs a signed immediate into the I/S/B/J
// bit positions of an instruction template.
//   clk, rst_n : clock, async active-low reset
//   bus        : imm_encoder_if slave (request in, result out, err_cnt)
// Stage 1 holds the accepted request and evaluates its range; stage 2 holds
// the packed instruction and err until the consumer takes them.
module imm_encoder
  import imm_encoder_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  imm_encoder_if.slave bus
);

  req_t                 s1_q, s1_d;
  logic                 s1_valid_q, s1_valid_d;
  logic                 out_valid_q, out_valid_d;
  logic [31:0]          instr_q, instr_d;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  logic        s2_load, s1_adv, accept, s1_err;
  logic [31:0] packed_w;

  imm_range_check u_range (
    .imm_i    (s1_q.imm),
    .immsrc_i (s1_q.src),
    .err_o    (s1_err)
  );

  // Stage 2 frees up whenever it is empty or being drained this cycle, so
  // in_ready sees out_ready combinationally and full rate is kept.
  assign s2_load  = !out_valid_q || bus.out_ready;
  assign s1_adv   = s1_valid_q && s2_load;
  assign accept   = bus.in_valid && bus.in_ready;

  assign bus.in_ready  = !s1_valid_q || s1_adv;
  assign bus.out_valid = out_valid_q;
  assign bus.instr     = instr_q;
  assign bus.err       = err_q;
  assign bus.err_cnt   = err_cnt_q;

  // Only immediate fields are overwritten; out-of-range values are truncated.
  always_comb begin
    packed_w = s1_q.base;
    case (s1_q.src)
      IMM_I: packed_w[31:20] = s1_q.imm[11:0];
      IMM_S: begin
        packed_w[31:25] = s1_q.imm[11:5];
        packed_w[11:7]  = s1_q.imm[4:0];
      end
      IMM_B: begin
        packed_w[31]    = s1_q.imm[12];
        packed_w[30:25] = s1_q.imm[10:5];
        packed_w[11:8]  = s1_q.imm[4:1];
        packed_w[7]     = s1_q.imm[11];
      end
      IMM_J: begin
        packed_w[31]    = s1_q.imm[20];
        packed_w[30:21] = s1_q.imm[10:1];
        packed_w[20]    = s1_q.imm[11];
        packed_w[19:12] = s1_q.imm[19:12];
      end
      default: packed_w = s1_q.base;
    endcase
  end

  always_comb begin
    s1_d        = s1_q;
    s1_valid_d  = s1_valid_q;
    out_valid_d = out_valid_q;
    instr_d     = instr_q;
    err_d       = err_q;
    err_cnt_d   = err_cnt_q;

    if (accept) begin
      s1_d.src   = immsrc_e'(bus.immsrc);
      s1_d.imm   = bus.imm;
      s1_d.base  = bus.base;
      s1_valid_d = 1'b1;
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end

    // Data is only replaced by a real stage-1 entry; an empty load just drops valid.
    if (s2_load) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        instr_d = packed_w;
        err_d   = s1_err;
      end
    end

    if (out_valid_q && bus.out_ready && err_q && !(&err_cnt_q))
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= '0;
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      instr_q     <= '0;
      err_q       <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      s1_q        <= s1_d;
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      instr_q     <= instr_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 The block SHALL have parameter ERR_CNT_W, default 8, giving the width of the saturating error counter.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, reset, asynchronous assert and active-low.
REQ-004 The block SHALL have port in_valid, input, 1, request valid.
REQ-005 The block SHALL have port in_ready, output, 1, request accepted when in_valid and in_ready are both high.
REQ-006 The block SHALL have port immsrc, input, 2, immediate format: 0=I, 1=S, 2=B, 3=J.
REQ-007 The block SHALL have port imm, input, 32, the signed immediate value to pack.
REQ-008 The block SHALL have port base, input, 32, the instruction template supplying every non-immediate bit.
REQ-009 The block SHALL have port out_valid, output, 1, result valid.
REQ-010 The block SHALL have port out_ready, input, 1, consumer ready.
REQ-011 The block SHALL have port instr, output, 32, the encoded instruction.
REQ-012 The block SHALL have port err, output, 1, high when imm is not representable in the selected format.
REQ-013 The block SHALL have port err_cnt, output, ERR_CNT_W, the count of delivered results with err set.

Function
REQ-014 The block SHALL encode by overwriting only the format's immediate bit positions in base, as follows:
- I: instr[31:20]=imm[11:0].
- S: [31:25]=imm[11:5], [11:7]=imm[4:0].
- B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
- J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
REQ-015 The block SHALL set err as follows:
- I/S: err when imm[31:11] are not all equal.
- B: err when imm[31:12] are not all equal, or imm[0]=1.
- J: err when imm[31:20] are not all equal, or imm[0]=1.
REQ-016 On err, instr SHALL still carry the truncated encoding per REQ-014.
REQ-017 The block SHALL be a two-stage pipeline:
- Stage 1 registers the request and computes err.
- Stage 2 holds instr/err and drives out_valid.
REQ-018 The latency from request acceptance to out_valid SHALL be exactly 2 cycles when out_ready is held high.
REQ-019 Stage 2 SHALL load when !out_valid || out_ready.
REQ-020 Stage 1 SHALL advance when it is valid and stage 2 loads.
REQ-021 in_ready SHALL equal !s1_valid || stage-1-advance; a combinational path from out_ready to in_ready is permitted.
REQ-022 Sustained throughput SHALL be one result per cycle with out_ready high.
REQ-023 With out_ready low, the block SHALL hold at most 2 results, drop nothing, and preserve order.
REQ-024 instr and err SHALL remain stable while out_valid && !out_ready.
REQ-025 err_cnt SHALL increment by one on each output handshake with err=1.
REQ-026 err_cnt SHALL saturate at all-ones and never wrap.
REQ-027 For err=0, sign-extending instr's immediate in format immsrc SHALL reproduce imm exactly.

Reset
REQ-028 rst_n low SHALL asynchronously clear s1_valid, out_valid and err_cnt to 0, and clear instr and err to 0.
REQ-029 In-flight requests SHALL be discarded on reset.
REQ-030 After rst_n deasserts, in_ready SHALL be 1.
REQ-031 The first request SHALL be accepted on the first rising edge with rst_n high.

Structure
REQ-032 A shared package SHALL hold:
- the immsrc enum (IMM_I=2'b00, IMM_S=2'b01, IMM_B=2'b10, IMM_J=2'b11);
- the per-format range widths (12, 12, 13, 21).
REQ-033 Range checking SHALL live in one combinational sub-module, imm_range_check (imm, immsrc -> err).
REQ-034 Packing and the pipeline SHALL remain in imm_encoder.

Verification
REQ-035 I-type encode: immsrc=0, imm=0xFFFFF800, base=0x00000013, out_ready=1 -> instr=0x80000013, err=0, out_valid exactly 2 cycles after acceptance.
REQ-036 S-type encode: immsrc=1, imm=0x000007FF, base=0x00002023 -> instr=0x7E002FA3, err=0.
REQ-037 B-type encode and error count:
- immsrc=2, imm=0xFFFFF000, base=0x00000063 -> instr=0x80000063, err=0.
- Then imm=0x00000FFF -> err=1, err_cnt 0->1.
- Then 300 error requests with ERR_CNT_W=8 -> err_cnt=0xFF.
REQ-038 Backpressure: 3 back-to-back requests with out_ready=0 for 5 cycles -> in_ready low after 2 accepts, third held upstream, all 3 delivered in order, each output stable while stalled.
REQ-039 Reset mid-operation: rst_n pulsed low with 2 results in flight -> out_valid and err_cnt drop to 0 immediately (no clock edge needed), nothing emitted afterward, in_ready=1.
REQ-040 J-type round-trip: 1000 random legal even imm in [-2^20, 2^20-2] -> err=0 and sign-extended J immediate of instr equals imm; out-of-range or odd imm -> err=1.
